// File: rtl/approx_mult_seq_ctrl.sv
// approx_mult_seq_ctrl
//   Sequencer for an accuracy-controllable shift-add multiplier. The W-bit
//   adder (add_x + add_y -> add_s, with carry-out) lives outside this block
//   and is shared. Each RUN cycle consumes one multiplier bit from P[0] and
//   adds the multiplicand into the upper half of P, then shifts P right.
//   The low k = min(acc_lvl, WIDTH) multiplier bits are dropped at load
//   time, so only WIDTH-k iterations run. The result is a*(b & ~(2^k-1)).
//   WIDTH must be at least 2.

module approx_mult_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int ACC_W = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [ACC_W-1:0]     acc_lvl,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic [WIDTH-1:0]     add_x,
  output logic [WIDTH-1:0]     add_y,
  input  logic [WIDTH:0]       add_s
);

  // Counter must hold WIDTH itself (all iterations, k = 0).
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  state_t               state_next;

  logic [WIDTH-1:0]     a_q;     // latched multiplicand
  logic [2*WIDTH-1:0]   p_q;     // partial product / remaining multiplier bits
  logic [CW-1:0]        cnt;     // iterations left in RUN

  logic [CW-1:0]        k_eff;   // effective skip count, clamped to WIDTH
  logic [CW-1:0]        n_iter;  // iterations to run for the request
  logic                 accept;
  logic                 last_iter;

  // Clamp the approximation level to the operand width.
  always_comb begin
    if (32'(acc_lvl) >= 32'(WIDTH)) begin
      k_eff = CW'(WIDTH);
    end else begin
      k_eff = CW'(acc_lvl);
    end
  end

  assign n_iter    = CW'(WIDTH) - k_eff;
  assign accept    = (state == IDLE) && in_valid;
  assign last_iter = (cnt == CW'(1));
  assign product   = p_q;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake/adder-operand outputs.
  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    add_x      = '0;
    add_y      = '0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          // With every bit skipped there is nothing to iterate: P loads as 0.
          state_next = (n_iter != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        add_x = p_q[2*WIDTH-1:WIDTH];
        add_y = p_q[0] ? a_q : '0;
        if (last_iter) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand load, shift-add iteration and iteration counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      p_q <= '0;
      cnt <= '0;
    end else if (accept) begin
      a_q <= a;
      // Skipped multiplier bits are folded into the load as a right shift.
      p_q <= {{WIDTH{1'b0}}, b} >> k_eff;
      cnt <= n_iter;
    end else if (state == RUN) begin
      // The adder carry-out becomes P[2W-1], so P never overflows.
      p_q <= {add_s, p_q[WIDTH-1:1]};
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: tb/tb_approx_mult_seq_ctrl.sv
// Bench for approx_mult_seq_ctrl: table vectors, randomized operations
// against an arithmetic reference model, DONE back-pressure, mid-RUN reset
// abort, and a wider-acc_lvl build where every multiplier bit is skipped.

module tb_approx_mult_seq_ctrl;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Main instance (ACC_W = 3).
  logic           in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]   a, b;
  logic [2:0]     acc;
  logic [2*W-1:0] product;
  logic [W-1:0]   add_x, add_y;
  logic [W:0]     add_s;

  // Wide-acc instance (ACC_W = 4), so k can reach W.
  logic           in_valid4, in_ready4, out_valid4, out_ready4;
  logic [W-1:0]   a4, b4;
  logic [3:0]     acc4;
  logic [2*W-1:0] product4;
  logic [W-1:0]   add_x4, add_y4;
  logic [W:0]     add_s4;

  // External shared adder, cin = 0.
  assign add_s  = {1'b0, add_x}  + {1'b0, add_y};
  assign add_s4 = {1'b0, add_x4} + {1'b0, add_y4};

  approx_mult_seq_ctrl #(.WIDTH(W), .ACC_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .acc_lvl(acc),
    .out_valid(out_valid), .out_ready(out_ready),
    .product(product),
    .add_x(add_x), .add_y(add_y), .add_s(add_s)
  );

  approx_mult_seq_ctrl #(.WIDTH(W), .ACC_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .acc_lvl(acc4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .product(product4),
    .add_x(add_x4), .add_y(add_y4), .add_s(add_s4)
  );

  int vec_count  = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_count++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain arithmetic from the accuracy rule.
  function automatic int model_k(input int lvl);
    return (lvl > W) ? W : lvl;
  endfunction

  function automatic int model_prod(input int op_a, input int op_b, input int lvl);
    int k;
    k = model_k(lvl);
    return op_a * ((op_b >> k) << k);
  endfunction

  function automatic int model_lat(input int lvl);
    return W - model_k(lvl) + 1;
  endfunction

  // One full operation on the main instance, with adder-operand checks in
  // every RUN cycle and an optional back-pressure hold in DONE.
  task automatic do_op(input int op_a, input int op_b, input int op_acc,
                       input int exp_p, input int exp_lat,
                       input int hold_cycles, input string tag);
    int k, c, i, exp_x, exp_y;
    logic [2*W-1:0] held;
    k = model_k(op_acc);
    @(negedge clk);
    a = W'(op_a); b = W'(op_b); acc = 3'(op_acc); in_valid = 1'b1;
    check({tag, " in_ready"}, 64'(in_ready), 64'd1);
    @(negedge clk);
    // Operand changes after acceptance must not matter.
    in_valid = 1'b0; a = W'($urandom); b = W'($urandom); acc = 3'($urandom);
    c = 1;
    while (out_valid !== 1'b1 && c < 40) begin
      if (c <= W - k) begin
        i = c - 1;
        exp_x = (op_a * ((op_b >> k) & ((1 << i) - 1))) >> i;
        exp_y = ((op_b >> (k + i)) & 1) ? op_a : 0;
        check({tag, " add_x"}, 64'(add_x), 64'(exp_x));
        check({tag, " add_y"}, 64'(add_y), 64'(exp_y));
      end
      @(negedge clk);
      c++;
    end
    check({tag, " latency"}, 64'(c), 64'(exp_lat));
    check({tag, " product"}, 64'(product), 64'(exp_p));
    check({tag, " in_ready_done"}, 64'(in_ready), 64'd0);
    check({tag, " add_x_idle"}, 64'({add_x, add_y}), 64'd0);
    held = product;
    for (int h = 0; h < hold_cycles; h++) begin
      in_valid = 1'b1; a = W'($urandom); b = W'($urandom);
      @(negedge clk);
      check({tag, " hold out_valid"}, 64'(out_valid), 64'd1);
      check({tag, " hold product"}, 64'(product), 64'(held));
      check({tag, " hold in_ready"}, 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " back_idle in_ready"}, 64'(in_ready), 64'd1);
    check({tag, " back_idle out_valid"}, 64'(out_valid), 64'd0);
  endtask

  typedef struct {
    int a;
    int b;
    int acc;
    int exp_p;
    int exp_lat;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int ra, rb, racc;

    tbl[0] = '{13,  11,  0, 143,   9};
    tbl[1] = '{255, 255, 0, 65025, 9};
    tbl[2] = '{200, 183, 3, 35200, 6};
    tbl[3] = '{0,   255, 0, 0,     9};
    tbl[4] = '{255, 1,   0, 255,   9};
    tbl[5] = '{1,   255, 7, 128,   2};
    tbl[6] = '{255, 255, 7, 32640, 2};
    tbl[7] = '{100, 200, 4, 19200, 5};

    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; acc = '0;
    in_valid4 = 1'b0; out_ready4 = 1'b0; a4 = '0; b4 = '0; acc4 = '0;

    #12;
    check("reset in_ready",  64'(in_ready),  64'd1);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset product",   64'(product),   64'd0);
    check("reset add_xy",    64'({add_x, add_y}), 64'd0);
    #1 rst_n = 1'b1;

    for (int v = 0; v < 8; v++) begin
      do_op(tbl[v].a, tbl[v].b, tbl[v].acc, tbl[v].exp_p, tbl[v].exp_lat, 0,
            $sformatf("tbl%0d", v));
    end

    // Back-pressure: 10 cycles in DONE with extra requests presented.
    do_op(13, 11, 0, 143, 9, 10, "hold");

    for (int r = 0; r < 30; r++) begin
      ra = int'($urandom_range(0, 255));
      rb = int'($urandom_range(0, 255));
      racc = int'($urandom_range(0, 7));
      do_op(ra, rb, racc, model_prod(ra, rb, racc), model_lat(racc), r % 3,
            $sformatf("rand%0d", r));
    end

    // Every bit skipped: zero RUN cycles, product 0.
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      a4 = 8'd255; b4 = 8'd255; acc4 = (s == 0) ? 4'd8 : (s == 1) ? 4'd12 : 4'd15;
      in_valid4 = 1'b1;
      check("skipall in_ready", 64'(in_ready4), 64'd1);
      @(negedge clk);
      in_valid4 = 1'b0;
      check("skipall out_valid", 64'(out_valid4), 64'd1);
      check("skipall product",   64'(product4),   64'(model_prod(255, 255, int'(acc4))));
      check("skipall add_xy",    64'({add_x4, add_y4}), 64'd0);
      out_ready4 = 1'b1;
      @(negedge clk);
      out_ready4 = 1'b0;
      check("skipall back_idle", 64'(in_ready4), 64'd1);
    end

    // Exact product on the wide-acc instance.
    @(negedge clk);
    a4 = 8'd200; b4 = 8'd183; acc4 = 4'd0; in_valid4 = 1'b1;
    @(negedge clk);
    in_valid4 = 1'b0;
    for (int c = 1; c < 9 && out_valid4 !== 1'b1; c++) @(negedge clk);
    check("wide exact product", 64'(product4), 64'(model_prod(200, 183, 0)));
    out_ready4 = 1'b1;
    @(negedge clk);
    out_ready4 = 1'b0;

    // Reset pulse during the 4th RUN cycle aborts the operation.
    @(negedge clk);
    a = 8'd200; b = 8'd183; acc = 3'd0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort out_valid", 64'(out_valid), 64'd0);
    check("abort in_ready",  64'(in_ready),  64'd1);
    check("abort product",   64'(product),   64'd0);
    check("abort add_xy",    64'({add_x, add_y}), 64'd0);
    #2 rst_n = 1'b1;
    do_op(7, 9, 0, 63, 9, 0, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
